// File: rtl/pingpong_clk_multi_axi.sv
// Multi-channel non-overlapping ping/pong clock generator.
// AXI4-Lite configured; NUM_CH output pairs share one phase FSM.
module pingpong_clk_multi_axi #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 5,
   parameter int NUM_CH             = 4,
   parameter int CNT_WIDTH          = 16
) (
   input  logic                            s00_axi_aclk,
   input  logic                            s00_axi_areset,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
   input  logic [2:0]                      s00_axi_awprot,
   input  logic                            s00_axi_awvalid,
   output logic                            s00_axi_awready,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
   input  logic                            s00_axi_wvalid,
   output logic                            s00_axi_wready,
   output logic [1:0]                      s00_axi_bresp,
   output logic                            s00_axi_bvalid,
   input  logic                            s00_axi_bready,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
   input  logic [2:0]                      s00_axi_arprot,
   input  logic                            s00_axi_arvalid,
   output logic                            s00_axi_arready,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
   output logic [1:0]                      s00_axi_rresp,
   output logic                            s00_axi_rvalid,
   input  logic                            s00_axi_rready,
   output logic [NUM_CH-1:0]               ping_o,
   output logic [NUM_CH-1:0]               pong_o,
   output logic                            busy_o,
   output logic                            done_irq_o
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      PING = 3'd1,
      GAP1 = 3'd2,
      PONG = 3'd3,
      GAP2 = 3'd4
   } state_t;

   state_t                state_q, state_n;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_n;
   logic                  en;
   logic                  done;
   logic [CNT_WIDTH-1:0]  phase_len;
   logic [CNT_WIDTH-1:0]  dead_len;
   logic [CNT_WIDTH-1:0]  burst_len;
   logic [NUM_CH-1:0]     ch_mask;
   logic [CNT_WIDTH-1:0]  period_cnt;
   logic [CNT_WIDTH-1:0]  period_inc;
   logic [CNT_WIDTH-1:0]  ph_ld;
   logic [CNT_WIDTH-1:0]  dd_ld;
   logic                  start;
   logic                  period_end;
   logic                  burst_done;
   logic                  wr_en;
   logic                  rd_en;
   logic [2:0]            waddr;
   logic [2:0]            raddr;
   logic                  sclr;
   logic [31:0]           rmux;
   logic                  unused_ok;

   assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot,
                        s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

   assign s00_axi_bresp = 2'b00;
   assign s00_axi_rresp = 2'b00;

   assign wr_en = s00_axi_awready && s00_axi_awvalid && s00_axi_wvalid;
   assign rd_en = s00_axi_arready && s00_axi_arvalid;
   assign waddr = s00_axi_awaddr[4:2];
   assign raddr = s00_axi_araddr[4:2];
   assign sclr  = wr_en && (waddr == 3'd0) && s00_axi_wstrb[0]
                  && s00_axi_wdata[1];

   assign busy_o     = (state_q != IDLE);
   assign period_inc = period_cnt + CNT_WIDTH'(1);
   // Counters hold "cycles remaining minus one"; zero phase still lasts one cycle.
   assign ph_ld = (phase_len == '0) ? '0 : phase_len - CNT_WIDTH'(1);
   assign dd_ld = dead_len - CNT_WIDTH'(1);

   function automatic logic [31:0] merge(input logic [31:0] old,
                                         input logic [31:0] d,
                                         input logic [3:0]  s);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) begin
         if (s[b]) r[8*b +: 8] = d[8*b +: 8];
      end
      return r;
   endfunction

   // AXI handshake: one-cycle ready pulses, response held until accepted.
   always_ff @(posedge s00_axi_aclk) begin
      if (s00_axi_areset) begin
         s00_axi_awready <= 1'b0;
         s00_axi_wready  <= 1'b0;
         s00_axi_bvalid  <= 1'b0;
         s00_axi_arready <= 1'b0;
         s00_axi_rvalid  <= 1'b0;
         s00_axi_rdata   <= '0;
      end else begin
         s00_axi_awready <= s00_axi_awvalid && s00_axi_wvalid
                            && !s00_axi_awready && !s00_axi_bvalid;
         s00_axi_wready  <= s00_axi_awvalid && s00_axi_wvalid
                            && !s00_axi_awready && !s00_axi_bvalid;
         if (wr_en) s00_axi_bvalid <= 1'b1;
         else if (s00_axi_bready) s00_axi_bvalid <= 1'b0;
         s00_axi_arready <= s00_axi_arvalid && !s00_axi_arready
                            && !s00_axi_rvalid;
         if (rd_en) begin
            s00_axi_rvalid <= 1'b1;
            s00_axi_rdata  <= rmux;
         end else if (s00_axi_rready) begin
            s00_axi_rvalid <= 1'b0;
         end
      end
   end

   // Read mux; unused bits and reserved word read as zero.
   always_comb begin
      rmux = '0;
      unique case (raddr)
         3'd0: rmux = {31'b0, en};
         3'd1: rmux = {30'b0, done, busy_o};
         3'd2: rmux = 32'(phase_len);
         3'd3: rmux = 32'(dead_len);
         3'd4: rmux = 32'(burst_len);
         3'd5: rmux = 32'(ch_mask);
         3'd6: rmux = 32'(period_cnt);
         default: rmux = '0;
      endcase
   end

   // Register file; the bus write is last so it overrides the hardware EN clear.
   always_ff @(posedge s00_axi_aclk) begin
      if (s00_axi_areset) begin
         en         <= 1'b0;
         done       <= 1'b0;
         phase_len  <= '0;
         dead_len   <= '0;
         burst_len  <= '0;
         ch_mask    <= '0;
         period_cnt <= '0;
      end else begin
         if (start) begin
            period_cnt <= '0;
            done       <= 1'b0;
         end
         if (period_end) period_cnt <= period_inc;
         if (burst_done) begin
            done <= 1'b1;
            en   <= 1'b0;
         end
         if (wr_en) begin
            unique case (waddr)
               3'd0: begin
                  if (s00_axi_wstrb[0]) begin
                     en <= s00_axi_wdata[0];
                     if (s00_axi_wdata[1]) begin
                        en         <= 1'b0;
                        done       <= 1'b0;
                        period_cnt <= '0;
                     end
                  end
               end
               3'd2: phase_len <= CNT_WIDTH'(merge(32'(phase_len),
                                  s00_axi_wdata, s00_axi_wstrb));
               3'd3: dead_len  <= CNT_WIDTH'(merge(32'(dead_len),
                                  s00_axi_wdata, s00_axi_wstrb));
               3'd4: burst_len <= CNT_WIDTH'(merge(32'(burst_len),
                                  s00_axi_wdata, s00_axi_wstrb));
               3'd5: ch_mask   <= NUM_CH'(merge(32'(ch_mask),
                                  s00_axi_wdata, s00_axi_wstrb));
               default: ;
            endcase
         end
      end
   end

   // Phase FSM state, counter and registered clock outputs.
   always_ff @(posedge s00_axi_aclk) begin
      if (s00_axi_areset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         ping_o     <= '0;
         pong_o     <= '0;
         done_irq_o <= 1'b0;
      end else begin
         state_q    <= state_n;
         cnt_q      <= cnt_n;
         ping_o     <= (state_n == PING) ? ch_mask : '0;
         pong_o     <= (state_n == PONG) ? ch_mask : '0;
         done_irq_o <= burst_done;
      end
   end

   // Next-state logic; lengths are sampled as each state is entered.
   always_comb begin
      state_n    = state_q;
      cnt_n      = cnt_q;
      start      = 1'b0;
      period_end = 1'b0;
      burst_done = 1'b0;
      if (sclr) begin
         state_n = IDLE;
      end else if (state_q != IDLE && !en) begin
         state_n = IDLE;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (en) begin
                  state_n = PING;
                  cnt_n   = ph_ld;
                  start   = 1'b1;
               end
            end
            PING: begin
               if (cnt_q != '0) begin
                  cnt_n = cnt_q - CNT_WIDTH'(1);
               end else if (dead_len == '0) begin
                  state_n = PONG;
                  cnt_n   = ph_ld;
               end else begin
                  state_n = GAP1;
                  cnt_n   = dd_ld;
               end
            end
            GAP1: begin
               if (cnt_q != '0) begin
                  cnt_n = cnt_q - CNT_WIDTH'(1);
               end else begin
                  state_n = PONG;
                  cnt_n   = ph_ld;
               end
            end
            PONG: begin
               if (cnt_q != '0) begin
                  cnt_n = cnt_q - CNT_WIDTH'(1);
               end else if (dead_len == '0) begin
                  period_end = 1'b1;
               end else begin
                  state_n = GAP2;
                  cnt_n   = dd_ld;
               end
            end
            GAP2: begin
               if (cnt_q != '0) cnt_n = cnt_q - CNT_WIDTH'(1);
               else period_end = 1'b1;
            end
            default: state_n = IDLE;
         endcase
         if (period_end) begin
            if (burst_len != '0 && period_inc == burst_len) begin
               burst_done = 1'b1;
               state_n    = IDLE;
            end else begin
               state_n = PING;
               cnt_n   = ph_ld;
            end
         end
      end
   end

endmodule

// File: doc/pingpong_clk_multi_axi.md
Name: pingpong_clk_multi_axi

Overview:
- Parametrised successor to the single-channel pingpong_clk AXI4-Lite IP.
- Generates NUM_CH pairs of non-overlapping two-phase (ping/pong) clocks for memristor array drive.
- Supports programmable phase width, dead time, burst length and per-channel mask.
- Configured over an AXI4-Lite slave by the PS; outputs go to the testboard DAC/switch fabric.

Parameters:
C_S_AXI_DATA_WIDTH, 32, AXI data width (fixed 32; other values unsupported)
C_S_AXI_ADDR_WIDTH, 5, byte address width (8 word registers)
NUM_CH, 4, number of ping/pong output pairs (1..32)
CNT_WIDTH, 16, width of the phase, dead-time and burst counters (1..32)

Ports:
s00_axi_aclk  in  1  sole clock
s00_axi_areset  in  1  synchronous, active-high reset
s00_axi_awaddr/awprot/awvalid/awready  AXI4-Lite write address channel (awprot ignored)
s00_axi_wdata/wstrb/wvalid/wready  AXI4-Lite write data channel, 32-bit data, 4-bit strobe
s00_axi_bresp/bvalid/bready  AXI4-Lite write response channel
s00_axi_araddr/arprot/arvalid/arready  AXI4-Lite read address channel (arprot ignored)
s00_axi_rdata/rresp/rvalid/rready  AXI4-Lite read data channel
ping_o  out  NUM_CH  phase-1 clock per channel
pong_o  out  NUM_CH  phase-2 clock per channel
busy_o  out  1  FSM not in IDLE
done_irq_o  out  1  one-cycle pulse when a burst completes

Behaviour:
- Reset: all ready/valid signals 0; bresp/rresp 0; rdata 0; ping_o, pong_o, busy_o and done_irq_o 0; all registers 0; FSM in IDLE.
- Register map (word-aligned; unused bits read 0):
  - 0x00 CTRL (RW): bit0 EN; bit1 SCLR (write-1, self-clears, reads 0).
  - 0x04 STATUS (RO): bit0 BUSY; bit1 DONE (sticky).
  - 0x08 PHASE_LEN (RW): CNT_WIDTH bits.
  - 0x0C DEAD_LEN (RW): CNT_WIDTH bits.
  - 0x10 BURST_LEN (RW): CNT_WIDTH bits; 0 = continuous.
  - 0x14 CH_MASK (RW): NUM_CH bits.
  - 0x18 PERIOD_CNT (RO): CNT_WIDTH bits, periods completed.
  - 0x1C: reserved.
- Write channel:
  - Waits until awvalid and wvalid are both high, then pulses awready and wready together for 1 cycle.
  - Register updates on that cycle, honouring wstrb per byte.
  - bvalid asserts the next cycle and holds until bready.
  - No new write is accepted while bvalid=1.
  - bresp is always OKAY, including writes to RO/reserved addresses, which are ignored.
- Read channel:
  - arready pulses 1 cycle when arvalid=1 and rvalid=0.
  - rdata/rvalid are registered the next cycle; rvalid holds until rready; rresp is OKAY.
  - Reserved address reads 0.
- Simultaneous read and write: both channels proceed independently. A read in the same cycle as a write to the same register returns the old value.
- FSM states: IDLE, PING, GAP1, PONG, GAP2.
  - IDLE->PING: the cycle after EN is seen 1. Clears PERIOD_CNT and DONE.
  - PING lasts max(PHASE_LEN,1) cycles, then GAP1.
  - GAP1 lasts DEAD_LEN cycles; 0 skips directly to PONG.
  - PONG lasts max(PHASE_LEN,1) cycles, then GAP2 (same rule as GAP1).
  - End of GAP2 increments PERIOD_CNT (wraps modulo 2^CNT_WIDTH).
  - If BURST_LEN != 0 and the incremented PERIOD_CNT == BURST_LEN: go to IDLE, set DONE, pulse done_irq_o for 1 cycle, clear EN in hardware.
  - Otherwise go back to PING.
  - PHASE_LEN and DEAD_LEN are sampled on entry to each state; a mid-state write takes effect at the next state.
- Outputs are registered:
  - ping_o = CH_MASK in PING, else 0; pong_o = CH_MASK in PONG, else 0.
  - ping_o and pong_o are never both nonzero for any channel.
  - CH_MASK changes apply from the next cycle.
- EN written 0 mid-burst: FSM goes to IDLE next cycle, outputs 0, DONE not set, PERIOD_CNT kept.
- SCLR=1: FSM to IDLE; PERIOD_CNT, DONE and EN cleared; config registers kept. SCLR wins over an EN=1 in the same write.
- Hardware EN clear and a bus write of CTRL in the same cycle: the bus write wins.
- Reset mid-operation: all state returns to reset values on the next clock edge; outputs 0.

Test Plan:
- Reset release -> every output 0; reads of 0x00–0x1C return 0, rresp=OKAY.
- Write 0x08=0x1234, 0x14=0xF with wstrb=4'b1111, then write 0x08=0xABCD with wstrb=4'b0001 -> 0x08 reads 0x12CD; 0x14 reads 0xF; write 0x04=0xFFFF and 0x1C=0xFFFF -> bresp OKAY, both read 0.
- PHASE_LEN=2, DEAD_LEN=1, BURST_LEN=3, CH_MASK=0xF, EN=1:
  - ping_o=0xF for 2 cycles, 0 for 1, pong_o=0xF for 2 cycles, 0 for 1, repeated 3×.
  - done_irq_o pulses once; STATUS reads 0x2; PERIOD_CNT=3; CTRL bit0 reads 0.
- DEAD_LEN=0, PHASE_LEN=0, BURST_LEN=0, mask=0x5 -> ping_o/pong_o alternate 0x5 every cycle with no gap, continuously. Write EN=0 -> both 0 the next cycle; DONE=0.
- Continuous run with PERIOD_CNT at 5: write CTRL=0x3 (EN+SCLR) -> FSM to IDLE; PERIOD_CNT=0; CTRL reads 0.
- AW asserted 3 cycles before W, with bready held low 4 cycles -> awready and wready pulse together once; bvalid held until bready; a second AW/W pair is not accepted until after the B handshake.
